// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset core: fetch/decode/exec/mem/wb/halt sequencing.
// Define MULTICYCLE_CTRL_TIMEOUT_EN to bound memory waits and raise a sticky timeout.
module multicycle_ctrl #(
   parameter int unsigned OP_W           = 6,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [OP_W-1:0] opcode,
   input  logic            imem_ack,
   input  logic            dmem_ack,
   input  logic            alu_zero,
   output logic            imem_req,
   output logic            dmem_req,
   output logic            mem_read,
   output logic            mem_write,
   output logic            ir_write,
   output logic            pc_inc,
   output logic            pc_branch,
   output logic            pc_jump,
   output logic            reg_write,
   output logic            reg_dst,
   output logic            mem_to_reg,
   output logic            alu_src,
   output logic [1:0]      alu_op,
   output logic            illegal,
   output logic            halted,
   output logic            timeout
);

   localparam logic [OP_W-1:0] OpR    = OP_W'('h00);
   localparam logic [OP_W-1:0] OpJ    = OP_W'('h02);
   localparam logic [OP_W-1:0] OpBeq  = OP_W'('h04);
   localparam logic [OP_W-1:0] OpAddi = OP_W'('h08);
   localparam logic [OP_W-1:0] OpLw   = OP_W'('h23);
   localparam logic [OP_W-1:0] OpSw   = OP_W'('h2B);
   localparam logic [OP_W-1:0] OpHalt = OP_W'('h3F);

   typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

   state_e          state_q, state_d;
   logic [OP_W-1:0] op_q;
   logic            to_hit;
   logic            timeout_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StFetch;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == StDecode) op_q <= opcode;
      end
   end

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            waiting;

   // Counter restarts whenever the FSM is not stalled on a memory handshake.
   always_comb begin
      waiting = ((state_q == StFetch) && !imem_ack) || ((state_q == StMem) && !dmem_ack);
      cnt_d   = waiting ? cnt_q + CntW'(1) : '0;
      to_hit  = waiting && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         if (to_hit) timeout_q <= 1'b1;
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^TIMEOUT_CYCLES;
   assign to_hit     = 1'b0;
   assign timeout_q  = 1'b0;
`endif

   assign timeout = rst_n & timeout_q;

   always_comb begin
      state_d    = state_q;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      pc_inc     = 1'b0;
      pc_branch  = 1'b0;
      pc_jump    = 1'b0;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src    = 1'b0;
      alu_op     = 2'b00;
      illegal    = 1'b0;
      halted     = 1'b0;

      case (state_q)
         StFetch: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_write = 1'b1;
               pc_inc   = 1'b1;
               state_d  = StDecode;
            end
         end
         StDecode: begin
            if (opcode == OpHalt) begin
               state_d = StHalt;
            end else if (opcode inside {OpR, OpJ, OpBeq, OpAddi, OpLw, OpSw}) begin
               state_d = StExec;
            end else begin
               illegal = 1'b1;
               state_d = StFetch;
            end
         end
         StExec: begin
            case (op_q)
               OpR: begin
                  alu_op  = 2'b10;
                  state_d = StWb;
               end
               OpAddi: begin
                  alu_src = 1'b1;
                  state_d = StWb;
               end
               OpLw, OpSw: begin
                  alu_src = 1'b1;
                  state_d = StMem;
               end
               OpBeq: begin
                  alu_op    = 2'b01;
                  pc_branch = alu_zero;
                  state_d   = StFetch;
               end
               OpJ: begin
                  pc_jump = 1'b1;
                  state_d = StFetch;
               end
               default: state_d = StFetch;
            endcase
         end
         StMem: begin
            dmem_req  = 1'b1;
            mem_read  = (op_q == OpLw);
            mem_write = (op_q == OpSw);
            if (dmem_ack) state_d = (op_q == OpLw) ? StWb : StFetch;
         end
         StWb: begin
            reg_write  = 1'b1;
            reg_dst    = (op_q == OpR);
            mem_to_reg = (op_q == OpLw);
            state_d    = StFetch;
         end
         StHalt: begin
            halted = 1'b1;
         end
         default: state_d = StFetch;
      endcase

      if (to_hit) state_d = StHalt;

      // Reset dominates: nothing leaks out while rst_n is low.
      if (!rst_n) begin
         imem_req   = 1'b0;
         dmem_req   = 1'b0;
         mem_read   = 1'b0;
         mem_write  = 1'b0;
         ir_write   = 1'b0;
         pc_inc     = 1'b0;
         pc_branch  = 1'b0;
         pc_jump    = 1'b0;
         reg_write  = 1'b0;
         reg_dst    = 1'b0;
         mem_to_reg = 1'b0;
         alu_src    = 1'b0;
         alu_op     = 2'b00;
         illegal    = 1'b0;
         halted     = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl: a per-instruction cycle-trace model
// predicts every output each cycle, with random memory latency and spurious acks.
module tb_multicycle_ctrl;

   localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_ADDI = 6'h08;
   localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2B, OP_HALT = 6'h3F;

   localparam logic [16:0] M_IREQ = 17'b1 << 16, M_DREQ = 17'b1 << 15, M_MRD = 17'b1 << 14;
   localparam logic [16:0] M_MWR = 17'b1 << 13, M_IRW = 17'b1 << 12, M_PCI = 17'b1 << 11;
   localparam logic [16:0] M_PCB = 17'b1 << 10, M_PCJ = 17'b1 << 9, M_RW = 17'b1 << 8;
   localparam logic [16:0] M_RDST = 17'b1 << 7, M_M2R = 17'b1 << 6, M_ASRC = 17'b1 << 5;
   localparam logic [16:0] A_SUB = 17'b01 << 3, A_FN = 17'b10 << 3;
   localparam logic [16:0] M_ILL = 17'b1 << 2, M_HLT = 17'b1 << 1, M_TO = 17'b1;

   typedef struct {
      logic        rst_n;
      logic        imem_ack;
      logic        dmem_ack;
      logic        alu_zero;
      logic [5:0]  opc;
      logic [16:0] exp;
   } cyc_t;

   logic clk = 1'b0;
   logic rst_n, imem_ack, dmem_ack, alu_zero;
   logic [5:0] opcode;
   logic imem_req, dmem_req, mem_read, mem_write, ir_write, pc_inc, pc_branch, pc_jump;
   logic reg_write, reg_dst, mem_to_reg, alu_src, illegal, halted, timeout;
   logic [1:0] alu_op;

   int vectors = 0;
   int miscompares = 0;
   cyc_t q[$];
   logic [16:0] got;

   always #5 clk = ~clk;

   multicycle_ctrl #(.OP_W(6), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
      .alu_zero(alu_zero), .imem_req(imem_req), .dmem_req(dmem_req), .mem_read(mem_read),
      .mem_write(mem_write), .ir_write(ir_write), .pc_inc(pc_inc), .pc_branch(pc_branch),
      .pc_jump(pc_jump), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .alu_src(alu_src), .alu_op(alu_op), .illegal(illegal), .halted(halted),
      .timeout(timeout)
   );

   function automatic logic rb();
      return 1'($urandom);
   endfunction

   function automatic logic [5:0] ro();
      return 6'($urandom);
   endfunction

   function automatic logic is_legal(logic [5:0] op);
      return op inside {OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
   endfunction

   function automatic void add(logic r, logic ia, logic da, logic az, logic [5:0] opc,
                               logic [16:0] e);
      cyc_t c;
      c.rst_n = r; c.imem_ack = ia; c.dmem_ack = da; c.alu_zero = az; c.opc = opc; c.exp = e;
      q.push_back(c);
   endfunction

   function automatic void add_reset(int n);
      for (int i = 0; i < n; i++) add(1'b0, rb(), rb(), rb(), ro(), '0);
   endfunction

   function automatic void add_halt(int n, logic [16:0] e);
      for (int i = 0; i < n; i++) add(1'b1, rb(), rb(), rb(), ro(), e);
   endfunction

   // One instruction: iw/dw = cycles a request waits before its ack arrives.
   function automatic void model_instr(logic [5:0] op, int iw, int dw, logic az);
      logic [16:0] qual;
      for (int i = 0; i < iw; i++) add(1'b1, 1'b0, rb(), rb(), ro(), M_IREQ);
      add(1'b1, 1'b1, rb(), rb(), ro(), M_IREQ | M_IRW | M_PCI);
      add(1'b1, rb(), rb(), rb(), op, (is_legal(op) || op == OP_HALT) ? 17'b0 : M_ILL);
      if (!is_legal(op)) return;
      case (op)
         OP_R: begin
            add(1'b1, rb(), rb(), rb(), ro(), A_FN);
            add(1'b1, rb(), rb(), rb(), ro(), M_RW | M_RDST);
         end
         OP_ADDI: begin
            add(1'b1, rb(), rb(), rb(), ro(), M_ASRC);
            add(1'b1, rb(), rb(), rb(), ro(), M_RW);
         end
         OP_BEQ: add(1'b1, rb(), rb(), az, ro(), A_SUB | (az ? M_PCB : 17'b0));
         OP_J:   add(1'b1, rb(), rb(), rb(), ro(), M_PCJ);
         default: begin
            qual = (op == OP_LW) ? M_MRD : M_MWR;
            add(1'b1, rb(), rb(), rb(), ro(), M_ASRC);
            for (int i = 0; i < dw; i++) add(1'b1, rb(), 1'b0, rb(), ro(), M_DREQ | qual);
            add(1'b1, rb(), 1'b1, rb(), ro(), M_DREQ | qual);
            if (op == OP_LW) add(1'b1, rb(), rb(), rb(), ro(), M_RW | M_M2R);
         end
      endcase
   endfunction

   task automatic drive(input cyc_t c, output logic [16:0] obs);
      @(posedge clk);
      #1;
      rst_n = c.rst_n; imem_ack = c.imem_ack; dmem_ack = c.dmem_ack;
      alu_zero = c.alu_zero; opcode = c.opc;
      #3;
      obs = {imem_req, dmem_req, mem_read, mem_write, ir_write, pc_inc, pc_branch, pc_jump,
             reg_write, reg_dst, mem_to_reg, alu_src, alu_op, illegal, halted, timeout};
   endtask

   task automatic test_reset();
      add_reset(3);
      model_instr(OP_SW, 1, 10, 1'b0);
      while (q.size() > 10) void'(q.pop_back());  // cut off three cycles into the MEM wait
      add_reset(3);
      model_instr(OP_ADDI, 0, 0, 1'b0);
      foreach (q[i]) begin
         drive(q[i], got);
         vectors++;
         if (got !== q[i].exp) begin
            miscompares++;
            $display("FAIL test_reset cycle %0d: got %05h expected %05h", i, got, q[i].exp);
         end
      end
      q.delete();
   endtask

   task automatic test_alu();
      model_instr(OP_ADDI, 1, 0, 1'b0);
      model_instr(OP_R, 1, 0, 1'b0);
      foreach (q[i]) begin
         drive(q[i], got);
         vectors++;
         if (got !== q[i].exp) begin
            miscompares++;
            $display("FAIL test_alu cycle %0d: got %05h expected %05h", i, got, q[i].exp);
         end
      end
      q.delete();
   endtask

   task automatic test_mem_wait();
      model_instr(OP_LW, 1, 4, 1'b0);
      model_instr(OP_SW, 2, 3, 1'b0);
      model_instr(OP_LW, 0, 0, 1'b0);
      foreach (q[i]) begin
         drive(q[i], got);
         vectors++;
         if (got !== q[i].exp) begin
            miscompares++;
            $display("FAIL test_mem_wait cycle %0d: got %05h expected %05h", i, got, q[i].exp);
         end
      end
      q.delete();
   endtask

   task automatic test_branch();
      model_instr(OP_BEQ, 1, 0, 1'b1);
      model_instr(OP_BEQ, 1, 0, 1'b0);
      model_instr(OP_J, 1, 0, 1'b1);
      foreach (q[i]) begin
         drive(q[i], got);
         vectors++;
         if (got !== q[i].exp) begin
            miscompares++;
            $display("FAIL test_branch cycle %0d: got %05h expected %05h", i, got, q[i].exp);
         end
      end
      q.delete();
   endtask

   task automatic test_back_to_back();
      logic [5:0] legal_ops [6] = '{OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
      logic [5:0] op;
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            do op = ro(); while (is_legal(op) || op == OP_HALT);
         end else begin
            op = legal_ops[$urandom_range(0, 5)];
         end
         model_instr(op, $urandom_range(0, 4), $urandom_range(0, 4), rb());
      end
      foreach (q[i]) begin
         drive(q[i], got);
         vectors++;
         if (got !== q[i].exp) begin
            miscompares++;
            $display("FAIL test_back_to_back cycle %0d: got %05h expected %05h", i, got,
                     q[i].exp);
         end
      end
      q.delete();
   endtask

   task automatic test_illegal_halt();
      model_instr(6'h3E, 1, 0, 1'b0);
      model_instr(OP_HALT, 1, 0, 1'b0);
      add_halt(20, M_HLT);
      add_reset(2);
      foreach (q[i]) begin
         drive(q[i], got);
         vectors++;
         if (got !== q[i].exp) begin
            miscompares++;
            $display("FAIL test_illegal_halt cycle %0d: got %05h expected %05h", i, got,
                     q[i].exp);
         end
      end
      q.delete();
   endtask

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
   task automatic test_timeout();
      int base;
      for (int i = 0; i < 16; i++) add(1'b1, 1'b0, rb(), rb(), ro(), M_IREQ);
      add_halt(5, M_HLT | M_TO);
      add_reset(2);
      model_instr(OP_ADDI, 15, 0, 1'b0);  // ack on the 16th request cycle wins
      model_instr(OP_SW, 0, 15, 1'b0);
      base = q.size();
      model_instr(OP_LW, 0, 30, 1'b0);
      while (q.size() > base + 19) void'(q.pop_back());
      add_halt(4, M_HLT | M_TO);
      add_reset(2);
      foreach (q[i]) begin
         drive(q[i], got);
         vectors++;
         if (got !== q[i].exp) begin
            miscompares++;
            $display("FAIL test_timeout cycle %0d: got %05h expected %05h", i, got, q[i].exp);
         end
      end
      q.delete();
   endtask
`else
   task automatic test_unbounded_wait();
      model_instr(OP_ADDI, 24, 0, 1'b0);
      model_instr(OP_LW, 0, 24, 1'b0);
      foreach (q[i]) begin
         drive(q[i], got);
         vectors++;
         if (got !== q[i].exp) begin
            miscompares++;
            $display("FAIL test_unbounded_wait cycle %0d: got %05h expected %05h", i, got,
                     q[i].exp);
         end
      end
      q.delete();
   endtask
`endif

   initial begin
      rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; alu_zero = 1'b0; opcode = '0;
      test_reset();
      test_alu();
      test_mem_wait();
      test_branch();
      test_back_to_back();
      test_illegal_halt();
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
      test_timeout();
`else
      test_unbounded_wait();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

endmodule
